serdesphy_tx_lane_pcs: RTL and testbench
========================================

// Module: serdesphy_tx_lane_pcs
// PURPOSE
//  Parametrised TX PCS lane: buffers DATA_W-bit parallel words in a FIFO and serialises them LSB-first to the PMA serializer.
//  Each word comes from one of three sources: FIFO data, PRBS7/PRBS15 pattern, or a programmable idle word.
//  Sits between the CSR/host TX interface and the serializer interface.
//  Runs entirely in the 240 MHz TX domain, one bit per clock.
//  Fills the TX slot currently tied off in the PCS top; replaces the fixed 4-bit, PRBS7-only plan.
// PARAMETERS
//  DATA_W      4        parallel word width (bits per serial frame), >=2
//  FIFO_DEPTH  8        TX FIFO entries, power of two, >=2
//  IDLE_WORD   4'b0101  word sent when idle or starved (width DATA_W)
//  PRBS_SEED   15'h7FFF LFSR reset seed; low 7 bits used in PRBS7 mode; must be non-zero
// PORTS
//  clk              in   1                240 MHz TX clock (clk_240m_tx at top)
//  rst              in   1                synchronous reset, active-high
//  tx_en            in   1                lane enable
//  tx_fifo_en       in   1                FIFO write/read enable
//  tx_prbs_en       in   1                PRBS generator enable (LFSR held at seed when 0)
//  prbs_mode        in   1                0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1)
//  tx_idle          in   1                force idle word
//  tx_data_sel      in   1                0=FIFO, 1=PRBS
//  tx_data          in   DATA_W           parallel write data
//  tx_valid         in   1                write strobe
//  clr_sticky       in   1                clear overflow/underflow flags
//  tx_serial_data   out  1                serial bit to serializer
//  tx_serial_valid  out  1                serial bit valid
//  tx_idle_pattern  out  1                current frame is idle word
//  tx_fifo_full     out  1                FIFO full
//  tx_fifo_empty    out  1                FIFO empty
//  tx_fifo_level    out  $clog2(DEPTH)+1  FIFO occupancy
//  tx_overflow      out  1                sticky: write while full
//  tx_underflow     out  1                sticky: FIFO frame slot with FIFO empty
//  tx_active        out  1                shifter running
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO emptied, level=0, empty=1, full=0, sticky flags=0,
//   LFSR=seed, bit_cnt=0, state DISABLED; all serial outputs 0, tx_active=0.
//  FIFO push: tx_valid & tx_fifo_en & (!full | pop same cycle).
//   Valid & fifo_en & full & no pop -> drop word, tx_overflow<=1.
//  Level/flags are registered. A word pushed at cycle N is poppable at cycle N+1.
//  FSM DISABLED -> RUN when tx_en=1. RUN -> DISABLED when tx_en=0; the current frame is abandoned immediately.
//  DISABLED: outputs 0, bit_cnt=0, FIFO still accepts writes.
//  RUN: bit_cnt counts 0..DATA_W-1 and wraps. Frame load happens at bit_cnt==0.
//   Source priority at load: tx_idle > tx_data_sel(PRBS) > FIFO.
//   FIFO source: non-empty & tx_fifo_en -> pop and load word.
//    Empty -> load IDLE_WORD, set tx_idle_pattern=1, and set tx_underflow<=1 if tx_fifo_en.
//   Source selects are sampled only at load; mid-frame changes take effect at the next frame.
//  Output registered: bit i of the loaded word appears on tx_serial_data i+1 cycles after load.
//   tx_serial_valid=1 and tx_active=1 while in RUN (1 cycle after entering).
//   tx_idle_pattern is held for the whole frame.
//  PRBS: in PRBS frames the LFSR advances once per output bit, and output = LFSR MSB for the mode.
//   LFSR is held when not in a PRBS frame.
//   tx_prbs_en=0 -> LFSR reloads seed and PRBS frames send zeros.
//   prbs_mode change reloads seed.
//  clr_sticky clears both flags; a set event in the same cycle wins (flag stays 1).
//  Simultaneous push+pop at full: both occur, level unchanged.
// STRUCTURE
//  Shared package serdesphy_pcs_pkg: PRBS7/PRBS15 tap constants, prbs_mode encodings, FSM state encoding.
//  Sub-module serdesphy_prbs_gen (mode, enable, advance, seed) is reused by the RX checker.
//  FIFO is inline (reg array + wrapping pointers with an extra MSB).
// TESTING
//  1 DATA_W=4: push 4'hA, 4'h3 then tx_en=1 -> serial 0,1,0,1,1,1,0,0; tx_idle_pattern=0; then idle frames 1,0,1,0 with tx_underflow=1.
//  2 Push 9 words into depth 8 with no tx_en -> full=1, level=8, tx_overflow=1; 9th word never transmitted; clr_sticky -> 0.
//  3 tx_data_sel=1, prbs_mode=0, seed all-ones -> first 14 bits match reference PRBS7 model; sequence period is 127 bits.
//  4 tx_idle=1 asserted mid-frame -> current frame completes unchanged; next frame is IDLE_WORD; FIFO level unchanged.
//  5 tx_en dropped mid-frame -> outputs 0 next cycle; re-enable restarts at bit 0 with the next FIFO word, no word lost or duplicated.
//  6 rst=1 while level=5 and overflow=1 -> all outputs and flags reset next cycle; DATA_W=8, DEPTH=4 regression of tests 1-2.

Source files
------------

// File: rtl/serdesphy_pcs_pkg.sv
// Shared PCS constants: PRBS polynomial taps, prbs_mode encodings, TX lane FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serdesphy_pcs_pkg;

  // LFSR is sized for the longest supported polynomial; PRBS7 uses the low 7 bits.
  localparam int PRBS_LFSR_W   = 15;
  localparam int PRBS7_LEN     = 7;

  // x^7 + x^6 + 1 and x^15 + x^14 + 1, expressed as register bit positions.
  localparam int PRBS7_TAP_HI  = 6;
  localparam int PRBS7_TAP_LO  = 5;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  localparam logic PRBS_MODE_7  = 1'b0;
  localparam logic PRBS_MODE_15 = 1'b1;

  typedef enum logic {
    ST_DISABLED = 1'b0,
    ST_RUN      = 1'b1
  } tx_state_t;

endpackage

// File: rtl/serdesphy_prbs_gen.sv
// PRBS7/PRBS15 Fibonacci LFSR; one step per cycle with i_advance, output is the polynomial MSB.
// Latency: o_bit is combinational from the current LFSR state; the state steps on the next clk.
// Backpressure: none; the LFSR only moves when i_advance is high, otherwise it holds.
// Ports: i_clk/i_rst (sync, active-high), i_mode (0=PRBS7, 1=PRBS15), i_enable (0 reloads
//        i_seed and forces o_bit low), i_advance (step once), i_seed, o_bit (pattern bit).
module serdesphy_prbs_gen
  import serdesphy_pcs_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mode,
  input  logic                   i_enable,
  input  logic                   i_advance,
  input  logic [PRBS_LFSR_W-1:0] i_seed,
  output logic                   o_bit
);

  logic [PRBS_LFSR_W-1:0] r_lfsr;
  logic                   r_mode;
  logic                   w_fb7;
  logic                   w_fb15;
  logic [PRBS_LFSR_W-1:0] w_lfsr_nxt;

  assign w_fb7  = r_lfsr[PRBS7_TAP_HI]  ^ r_lfsr[PRBS7_TAP_LO];
  assign w_fb15 = r_lfsr[PRBS15_TAP_HI] ^ r_lfsr[PRBS15_TAP_LO];

  // In PRBS7 mode the upper bits are left untouched so only the low 7 bits move.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (i_mode == PRBS_MODE_15) begin
      w_lfsr_nxt = {r_lfsr[PRBS_LFSR_W-2:0], w_fb15};
    end else begin
      w_lfsr_nxt = {r_lfsr[PRBS_LFSR_W-1:PRBS7_LEN], r_lfsr[PRBS7_LEN-2:0], w_fb7};
    end
  end

  // A mode change restarts the sequence from the seed so the new pattern begins cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= i_seed;
      r_mode <= PRBS_MODE_7;
    end else begin
      r_mode <= i_mode;
      if (!i_enable || (i_mode != r_mode)) begin
        r_lfsr <= i_seed;
      end else if (i_advance) begin
        r_lfsr <= w_lfsr_nxt;
      end
    end
  end

  assign o_bit = i_enable &
                 ((i_mode == PRBS_MODE_15) ? r_lfsr[PRBS15_TAP_HI] : r_lfsr[PRBS7_TAP_HI]);

endmodule

// File: rtl/serdesphy_tx_lane_pcs.sv
// TX PCS lane: FIFO-buffered parallel words (or PRBS / idle) serialised LSB-first, one bit per clk.
// Latency: word pushed at N is poppable at N+1; bit i of a frame appears i+1 cycles after its load.
// Backpressure: none toward the host; a write while full is dropped and flagged in tx_overflow.
// Ports: clk/rst (sync, active-high); tx_en, tx_fifo_en, tx_prbs_en, prbs_mode, tx_idle,
//        tx_data_sel, tx_data/tx_valid (host write), clr_sticky; tx_serial_data/valid,
//        tx_idle_pattern, tx_fifo_full/empty/level, tx_overflow/underflow (sticky), tx_active.
module serdesphy_tx_lane_pcs
  import serdesphy_pcs_pkg::*;
#(
  parameter int                     DATA_W     = 4,
  parameter int                     FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0]      IDLE_WORD  = 4'b0101,
  parameter logic [PRBS_LFSR_W-1:0] PRBS_SEED  = 15'h7FFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic                          tx_fifo_en,
  input  logic                          tx_prbs_en,
  input  logic                          prbs_mode,
  input  logic                          tx_idle,
  input  logic                          tx_data_sel,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  input  logic                          clr_sticky,
  output logic                          tx_serial_data,
  output logic                          tx_serial_valid,
  output logic                          tx_idle_pattern,
  output logic                          tx_fifo_full,
  output logic                          tx_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level,
  output logic                          tx_overflow,
  output logic                          tx_underflow,
  output logic                          tx_active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic              w_run;
  logic              w_load;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_overflow;
  logic              r_underflow;

  logic [CW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_prbs;
  logic              r_idle_pat;
  logic              r_ser_data;
  logic              r_ser_vld;

  logic              w_empty;
  logic              w_full;
  logic              w_src_idle;
  logic              w_src_prbs;
  logic              w_src_fifo;
  logic              w_pop;
  logic              w_push;
  logic              w_starve;
  logic              w_overflow_set;
  logic              w_underflow_set;
  logic              w_prbs_frame;
  logic              w_prbs_bit;
  logic [DATA_W-1:0] w_load_word;

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_DISABLED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DISABLED: if (tx_en)  w_state_nxt = ST_RUN;
      ST_RUN:      if (!tx_en) w_state_nxt = ST_DISABLED;
      default:     w_state_nxt = ST_DISABLED;
    endcase
  end

  // Gating on tx_en as well abandons the current frame on the very edge tx_en is seen low.
  always_comb begin
    w_run  = (r_state == ST_RUN) && tx_en;
    w_load = w_run && (r_bit_cnt == '0);
  end

  // ---------------- source selection at frame load ----------------
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(FIFO_DEPTH));

  assign w_src_idle = tx_idle;
  assign w_src_prbs = !tx_idle && tx_data_sel;
  assign w_src_fifo = !tx_idle && !tx_data_sel;

  assign w_pop      = w_load && w_src_fifo && !w_empty && tx_fifo_en;
  // FIFO slot that cannot be served (empty, or FIFO disabled) sends the idle word instead.
  assign w_starve   = w_load && w_src_fifo && !w_pop;

  assign w_push          = tx_valid && tx_fifo_en && (!w_full || w_pop);
  assign w_overflow_set  = tx_valid && tx_fifo_en && w_full && !w_pop;
  assign w_underflow_set = w_starve && tx_fifo_en;

  assign w_load_word  = w_pop ? r_mem[r_rd_ptr[AW-1:0]] : IDLE_WORD;

  // The PRBS decision is latched at load and applies to every bit of that frame.
  assign w_prbs_frame = w_load ? w_src_prbs : r_frame_prbs;

  serdesphy_prbs_gen u_prbs (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mode    (prbs_mode),
    .i_enable  (tx_prbs_en),
    .i_advance (w_run && w_prbs_frame),
    .i_seed    (PRBS_SEED),
    .o_bit     (w_prbs_bit)
  );

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_overflow_set  | (r_overflow  & ~clr_sticky);
      r_underflow <= w_underflow_set | (r_underflow & ~clr_sticky);
    end
  end

  // ---------------- serialiser ----------------
  // Bit 0 is emitted straight from the loaded word; the rest shift out of r_shift.
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_frame_prbs <= 1'b0;
      r_idle_pat   <= 1'b0;
      r_ser_data   <= 1'b0;
      r_ser_vld    <= 1'b0;
    end else begin
      r_ser_vld <= 1'b1;
      r_bit_cnt <= (r_bit_cnt == CW'(DATA_W - 1)) ? '0 : r_bit_cnt + 1'b1;
      if (w_load) begin
        r_frame_prbs <= w_src_prbs;
        r_idle_pat   <= w_src_idle || w_starve;
      end
      if (w_prbs_frame) begin
        r_ser_data <= w_prbs_bit;
      end else if (w_load) begin
        r_ser_data <= w_load_word[0];
        r_shift    <= w_load_word >> 1;
      end else begin
        r_ser_data <= r_shift[0];
        r_shift    <= r_shift >> 1;
      end
    end
  end

  assign tx_serial_data  = r_ser_data;
  assign tx_serial_valid = r_ser_vld;
  assign tx_active       = r_ser_vld;
  assign tx_idle_pattern = r_idle_pat;
  assign tx_fifo_full    = w_full;
  assign tx_fifo_empty   = w_empty;
  assign tx_fifo_level   = r_level;
  assign tx_overflow     = r_overflow;
  assign tx_underflow    = r_underflow;

endmodule

// File: tb/tb_serdesphy_tx_lane_pcs.sv
// Directed bench for serdesphy_tx_lane_pcs: a default lane (DATA_W=4, depth 8) and an
// 8-bit, depth-4 lane share control inputs; each step drives inputs and checks with
// immediate assertions against hand-computed values.
module tb_serdesphy_tx_lane_pcs;

  logic       clk = 1'b0;
  logic       rst, tx_en, tx_fifo_en, tx_prbs_en, prbs_mode, tx_idle, tx_data_sel;
  logic       tx_valid, clr_sticky;
  logic [7:0] d8;

  logic       sd_a, sv_a, ip_a, full_a, empty_a, ovf_a, unf_a, act_a;
  logic [3:0] lvl_a;
  logic       sd_b, sv_b, ip_b, full_b, empty_b, ovf_b, unf_b, act_b;
  logic [2:0] lvl_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serdesphy_tx_lane_pcs u_dut_a (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_fifo_en(tx_fifo_en), .tx_prbs_en(tx_prbs_en),
    .prbs_mode(prbs_mode), .tx_idle(tx_idle), .tx_data_sel(tx_data_sel), .tx_data(d8[3:0]),
    .tx_valid(tx_valid), .clr_sticky(clr_sticky), .tx_serial_data(sd_a),
    .tx_serial_valid(sv_a), .tx_idle_pattern(ip_a), .tx_fifo_full(full_a),
    .tx_fifo_empty(empty_a), .tx_fifo_level(lvl_a), .tx_overflow(ovf_a),
    .tx_underflow(unf_a), .tx_active(act_a)
  );

  serdesphy_tx_lane_pcs #(.DATA_W(8), .FIFO_DEPTH(4), .IDLE_WORD(8'hC5)) u_dut_b (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_fifo_en(tx_fifo_en), .tx_prbs_en(tx_prbs_en),
    .prbs_mode(prbs_mode), .tx_idle(tx_idle), .tx_data_sel(tx_data_sel), .tx_data(d8),
    .tx_valid(tx_valid), .clr_sticky(clr_sticky), .tx_serial_data(sd_b),
    .tx_serial_valid(sv_b), .tx_idle_pattern(ip_b), .tx_fifo_full(full_b),
    .tx_fifo_empty(empty_b), .tx_fifo_level(lvl_b), .tx_overflow(ovf_b),
    .tx_underflow(unf_b), .tx_active(act_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    tx_valid = 1'b1;
    d8       = v;
    tick();
    tx_valid = 1'b0;
  endtask

  // Collects w serial bits LSB-first; idl is the AND of tx_idle_pattern over the frame.
  task automatic read_frame(input bit b, input int w, output logic [7:0] word, output logic idl);
    word = '0;
    idl  = 1'b1;
    for (int i = 0; i < w; i++) begin
      tick();
      word[i] = b ? sd_b : sd_a;
      idl     = idl & (b ? ip_b : ip_a);
    end
  endtask

  initial begin
    logic [7:0]  w;
    logic        idl;
    logic        b0;
    logic [7:0]  t1_bits;
    logic [13:0] prbs_hand;
    logic        ref_bits [144];
    logic        got_bits [144];

    rst = 1'b1; tx_en = 1'b0; tx_fifo_en = 1'b0; tx_prbs_en = 1'b0; prbs_mode = 1'b0;
    tx_idle = 1'b0; tx_data_sel = 1'b0; tx_valid = 1'b0; clr_sticky = 1'b0; d8 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_outputs_a", 32'({sd_a, sv_a, ip_a, act_a}), 32'h0);
    chk("rst_fifo_a", 32'({full_a, empty_a, lvl_a}), 32'({1'b0, 1'b1, 4'd0}));
    chk("rst_sticky_a", 32'({ovf_a, unf_a}), 32'h0);

    // 1: two FIFO words then idle frames with underflow
    tx_fifo_en = 1'b1;
    push(8'h0A);
    push(8'h03);
    chk("t1_level", 32'(lvl_a), 32'd2);
    tx_en = 1'b1;
    tick();
    chk("t1_enter_vld", 32'(sv_a), 32'd0);
    t1_bits = 8'b0011_1010;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_bit", 32'(sd_a), 32'(t1_bits[i]));
      chk("t1_vld_act", 32'({sv_a, act_a, ip_a}), 32'b110);
    end
    read_frame(1'b0, 4, w, idl);
    chk("t1_idle_word", 32'(w), 32'h5);
    chk("t1_idle_pat", 32'(idl), 32'd1);
    chk("t1_underflow", 32'(unf_a), 32'd1);
    tx_en = 1'b0;
    tick();
    chk("t1_disabled", 32'({sd_a, sv_a, ip_a, act_a}), 32'h0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t1_unf_clr", 32'(unf_a), 32'd0);

    // 2: overfill depth 8, set-beats-clear, ninth word never sent
    for (int i = 1; i <= 9; i++) push(8'(i));
    chk("t2_full_level", 32'({full_a, empty_a, lvl_a}), 32'({1'b1, 1'b0, 4'd8}));
    chk("t2_overflow", 32'(ovf_a), 32'd1);
    clr_sticky = 1'b1;
    tx_valid   = 1'b1;
    d8         = 8'h09;
    tick();
    tx_valid = 1'b0;
    chk("t2_set_wins", 32'(ovf_a), 32'd1);
    tick();
    clr_sticky = 1'b0;
    chk("t2_ovf_clr", 32'(ovf_a), 32'd0);
    tx_en = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      read_frame(1'b0, 4, w, idl);
      chk("t2_word", 32'(w), 32'(k));
      chk("t2_not_idle", 32'(idl), 32'd0);
    end
    read_frame(1'b0, 4, w, idl);
    chk("t2_no_ninth", 32'({idl, w}), 32'h105);
    tx_en = 1'b0;
    tick();

    // 5: tx_en dropped mid-frame
    push(8'h0A);
    push(8'h0B);
    push(8'h0C);
    chk("t5_level", 32'(lvl_a), 32'd3);
    tx_en = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_mid_bit1", 32'(sd_a), 32'd1);
    tx_en = 1'b0;
    tick();
    chk("t5_abandon", 32'({sd_a, sv_a, act_a}), 32'h0);
    chk("t5_level_after", 32'(lvl_a), 32'd2);
    tx_en = 1'b1;
    tick();
    read_frame(1'b0, 4, w, idl);
    chk("t5_next_word", 32'(w), 32'hB);
    read_frame(1'b0, 4, w, idl);
    chk("t5_following", 32'(w), 32'hC);
    tx_en = 1'b0;
    tick();
    chk("t5_drained", 32'(lvl_a), 32'd0);

    // 4: tx_idle raised mid-frame
    push(8'h0E);
    push(8'h06);
    tx_en = 1'b1;
    tick();
    tick();
    b0      = sd_a;
    tx_idle = 1'b1;
    read_frame(1'b0, 3, w, idl);
    chk("t4_frame_intact", 32'({w[2:0], b0}), 32'hE);
    chk("t4_frame_not_idle", 32'(idl), 32'd0);
    read_frame(1'b0, 4, w, idl);
    chk("t4_idle_frame", 32'({idl, w}), 32'h105);
    chk("t4_level_held", 32'(lvl_a), 32'd1);
    tx_idle = 1'b0;
    read_frame(1'b0, 4, w, idl);
    chk("t4_resume", 32'({idl, w}), 32'h006);
    tx_en = 1'b0;
    tick();

    // 3: PRBS7 from all-ones seed
    prbs_hand = 14'h207F;
    for (int n = 0; n < 144; n++) begin
      ref_bits[n] = (n < 7) ? 1'b1 : (ref_bits[n-6] ^ ref_bits[n-7]);
    end
    tx_data_sel = 1'b1;
    tx_prbs_en  = 1'b1;
    prbs_mode   = 1'b0;
    tx_en       = 1'b1;
    tick();
    for (int n = 0; n < 144; n++) begin
      tick();
      got_bits[n] = sd_a;
      chk("t3_prbs_model", 32'(got_bits[n]), 32'(ref_bits[n]));
    end
    for (int n = 0; n < 14; n++) begin
      chk("t3_prbs_first14", 32'(got_bits[n]), 32'(prbs_hand[n]));
      chk("t3_prbs_period", 32'(got_bits[n+127]), 32'(prbs_hand[n]));
    end
    tx_prbs_en = 1'b0;
    read_frame(1'b0, 4, w, idl);
    chk("t3_prbs_off_zero", 32'({idl, w}), 32'h000);
    tx_prbs_en = 1'b1;
    read_frame(1'b0, 4, w, idl);
    chk("t3_prbs_reseeded", 32'(w), 32'hF);
    tx_en       = 1'b0;
    tx_data_sel = 1'b0;
    tick();

    // 6: reset at level 5 with overflow and underflow set
    for (int i = 1; i <= 9; i++) push(8'(i));
    tx_en = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    chk("t6_pre_level", 32'(lvl_a), 32'd5);
    chk("t6_pre_sticky", 32'({ovf_a, unf_a, sv_a}), 32'b111);
    rst = 1'b1;
    tick();
    chk("t6_rst_a", 32'({sd_a, sv_a, ip_a, act_a, full_a, empty_a, ovf_a, unf_a, lvl_a}),
        32'h040);
    chk("t6_rst_b", 32'({sd_b, sv_b, ip_b, act_b, full_b, empty_b, ovf_b, unf_b, lvl_b}),
        32'h020);
    tx_en = 1'b0;
    tick();
    rst = 1'b0;

    // Regression on DATA_W=8, depth 4
    push(8'hA5);
    push(8'h3C);
    chk("b1_level", 32'(lvl_b), 32'd2);
    tx_en = 1'b1;
    tick();
    read_frame(1'b1, 8, w, idl);
    chk("b1_word0", 32'({idl, w}), 32'h0A5);
    read_frame(1'b1, 8, w, idl);
    chk("b1_word1", 32'({idl, w}), 32'h03C);
    read_frame(1'b1, 8, w, idl);
    chk("b1_idle", 32'({idl, w}), 32'h1C5);
    chk("b1_underflow", 32'(unf_b), 32'd1);
    tx_en = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("b2_full_level", 32'({full_b, lvl_b}), 32'({1'b1, 3'd4}));
    chk("b2_overflow", 32'(ovf_b), 32'd1);
    tx_en = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      read_frame(1'b1, 8, w, idl);
      chk("b2_word", 32'({idl, w}), 32'(k));
    end
    read_frame(1'b1, 8, w, idl);
    chk("b2_no_fifth", 32'({idl, w}), 32'h1C5);
    tx_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
